// File: rtl/rv_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// default geometry and error-cause codes.
package rv_loader_pkg;

  localparam int LOADER_ADDR_W = 12;
  localparam int LOADER_DATA_W = 32;
  localparam int LOADER_DEPTH  = 4096;
  localparam int CSUM_W        = 32;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_CHECK = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERR   = 3'd5
  } loader_state_e;

  // States in which the loader consumes stream words.
  function automatic logic state_busy(input loader_state_e s);
    return (s == ST_LEN) || (s == ST_LOAD) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/loader_checksum.sv
// Running mod-2^32 sum of payload words; only instantiated when
// LOADER_CHECKSUM_EN is defined.
module loader_checksum
  import rv_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [CSUM_W-1:0] word,
  output logic [CSUM_W-1:0] sum
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (enable) begin
      sum <= sum + word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: takes a length-framed word stream, writes it into the core's
// instruction RAM, then releases the core. Optional trailer check: LOADER_CHECKSUM_EN.
module imem_loader
  import rv_loader_pkg::*;
#(
  parameter int ADDR_W = LOADER_ADDR_W,
  parameter int DATA_W = LOADER_DATA_W,
  parameter int DEPTH  = LOADER_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_run,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  loader_state_e   state, state_nxt;
  logic [ADDR_W:0] len_q;
  logic            accept;
  logic            start_ok;
  logic            len_bad;
  logic            last_word;

  assign accept    = s_valid && s_ready;
  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_RUN) || (state == ST_ERR));
  assign len_bad   = (s_data == '0) || ({1'b0, s_data} > (DATA_W + 1)'(DEPTH));
  assign last_word = (words_loaded + (ADDR_W + 1)'(1)) == len_q;

`ifdef LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0] csum;
  logic              csum_ok;

  loader_checksum u_checksum (
    .clk    (clk),
    .reset  (reset),
    .clear  ((state == ST_IDLE) || start_ok),
    .enable ((state == ST_LOAD) && accept),
    .word   (s_data[CSUM_W-1:0]),
    .sum    (csum)
  );

  assign csum_ok = (s_data[CSUM_W-1:0] == csum);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        if (accept) state_nxt = len_bad ? ST_ERR : ST_LOAD;
      end
      ST_LOAD: begin
`ifdef LOADER_CHECKSUM_EN
        if (accept && last_word) state_nxt = ST_CHECK;
`else
        if (accept && last_word) state_nxt = ST_RUN;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) state_nxt = csum_ok ? ST_RUN : ST_ERR;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status flags follow the next state; core_run lags entry into RUN by one
  // cycle so the core only leaves reset after the final RAM write has landed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      len_q        <= '0;
      s_ready      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      core_run     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      state    <= state_nxt;
      s_ready  <= state_busy(state_nxt);
      busy     <= state_busy(state_nxt);
      done     <= (state_nxt == ST_RUN);
      err      <= (state_nxt == ST_ERR);
      core_run <= (state == ST_RUN) && (state_nxt == ST_RUN);
      mem_we   <= 1'b0;

      if ((state == ST_IDLE) || start_ok) begin
        words_loaded <= '0;
      end

      if ((state == ST_LEN) && accept) begin
        len_q <= s_data[ADDR_W:0];
      end

      if ((state == ST_LOAD) && accept) begin
        mem_we       <= 1'b1;
        mem_addr     <= words_loaded[ADDR_W-1:0];
        mem_wdata    <= s_data;
        words_loaded <= words_loaded + (ADDR_W + 1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a frame-level reference model;
// follows LOADER_CHECKSUM_EN the same way as the design.
module tb_imem_loader;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4096;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef logic [31:0] word_q_t[$];
  typedef enum int {P_IDLE, P_LEN, P_BODY, P_SUM, P_RUN, P_FAIL} phase_e;
  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_ready, mem_we, core_run, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_run     (core_run),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  model_valid = 1'b0;

  phase_e      m_phase = P_IDLE;
  int          m_n = 0;
  int          m_loaded = 0;
  logic [31:0] m_sum = '0;
  logic        m_we = 1'b0;
  logic [11:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic        m_run = 1'b0;

  wr_t         wr_log[$];
  int          rise_cyc = -1;
  logic        core_run_q = 1'b0;
  logic [31:0] basic_pl[3] = '{32'h00500093, 32'h00A00113, 32'h002081B3};

  function automatic bit isBusy(input phase_e p);
    return (p == P_LEN) || (p == P_BODY) || (p == P_SUM);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: advances once per clock from the stimulus alone.
  always @(posedge clk) begin
    bit was_run;
    bit acc;
    cyc++;
    if (!reset) begin
      m_phase  = P_IDLE;
      m_n      = 0;
      m_loaded = 0;
      m_sum    = '0;
      m_we     = 1'b0;
      m_addr   = '0;
      m_wdata  = '0;
      m_run    = 1'b0;
    end else begin
      was_run = (m_phase == P_RUN);
      acc     = s_valid && isBusy(m_phase);
      m_we    = 1'b0;
      case (m_phase)
        P_IDLE, P_RUN, P_FAIL: begin
          if (start) begin
            m_phase  = P_LEN;
            m_loaded = 0;
            m_sum    = '0;
          end
        end
        P_LEN: begin
          if (acc) begin
            if (s_data == 0 || s_data > DEPTH) m_phase = P_FAIL;
            else begin
              m_n     = int'(s_data);
              m_phase = P_BODY;
            end
          end
        end
        P_BODY: begin
          if (acc) begin
            m_we    = 1'b1;
            m_addr  = 12'(m_loaded);
            m_wdata = s_data;
            m_loaded++;
            m_sum   = m_sum + s_data;
            if (m_loaded == m_n) m_phase = CSUM_EN ? P_SUM : P_RUN;
          end
        end
        P_SUM: begin
          if (acc) m_phase = (s_data == m_sum) ? P_RUN : P_FAIL;
        end
        default: m_phase = P_IDLE;
      endcase
      m_run = was_run && (m_phase == P_RUN);
    end
    model_valid = 1'b1;
  end

  // Compare process: every output, every cycle, mid-cycle.
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("s_ready", s_ready, isBusy(m_phase));
      checkOutput("busy", busy, isBusy(m_phase));
      checkOutput("done", done, m_phase == P_RUN);
      checkOutput("err", err, m_phase == P_FAIL);
      checkOutput("core_run", core_run, m_run);
      checkOutput("mem_we", mem_we, m_we);
      checkOutput("mem_addr", mem_addr, m_addr);
      checkOutput("mem_wdata", mem_wdata, m_wdata);
      checkOutput("words_loaded", words_loaded, m_loaded);
      if (mem_we === 1'b1) wr_log.push_back('{cyc, mem_addr, mem_wdata});
      if (core_run === 1'b1 && core_run_q !== 1'b1) rise_cyc = cyc;
      core_run_q = core_run;
    end
  end

  function automatic word_q_t makeFrame(input int hdr, input int cnt, input bit bad_sum);
    word_q_t     f;
    logic [31:0] w;
    logic [31:0] s = '0;
    f.push_back(32'(hdr));
    for (int i = 0; i < cnt; i++) begin
      w = $urandom;
      s = s + w;
      f.push_back(w);
    end
    if (CSUM_EN) f.push_back(bad_sum ? s + 32'd1 : s);
    return f;
  endfunction

  function automatic word_q_t basicFrame(input bit bad_sum);
    word_q_t f;
    f.push_back(32'd3);
    for (int i = 0; i < 3; i++) f.push_back(basic_pl[i]);
    // True mod-2^32 sum of the three payload words.
    if (CSUM_EN) f.push_back(bad_sum ? 32'h0110835A : 32'h01108359);
    return f;
  endfunction

  task automatic idleCycles(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start   = 1'b0;
      s_valid = noise ? 1'($urandom_range(1)) : 1'b0;
      s_data  = $urandom;
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic applyStimulus(input word_q_t words, input int gap_pct, input bit start_noise,
                               input int reset_at);
    @(negedge clk);
    s_valid = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < words.size(); i++) begin
      bit sent  = 1'b0;
      int tries = 0;
      while (!sent) begin
        if (!isBusy(m_phase)) begin
          s_valid = 1'b0;
          start   = 1'b0;
          return;
        end
        if (i == reset_at) begin
          reset   = 1'b0;
          s_valid = 1'b1;
          s_data  = words[i];
          @(negedge clk);
          reset   = 1'b1;
          s_valid = 1'b0;
          return;
        end
        start = start_noise && ($urandom_range(99) < 20);
        tries++;
        if (tries < 50 && $urandom_range(99) < gap_pct) begin
          s_valid = 1'b0;
          s_data  = $urandom;
        end else begin
          s_valid = 1'b1;
          s_data  = words[i];
          sent    = 1'b1;
        end
        @(negedge clk);
      end
    end
    s_valid = 1'b0;
    start   = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    word_q_t f;
    int      last;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_core_run", core_run, 0);
    checkOutput("rst_s_ready", s_ready, 0);
    checkOutput("rst_words_loaded", words_loaded, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    reset = 1'b1;
    idleCycles(4, 1'b1);

    $display("[TB] basic load");
    wr_log.delete();
    applyStimulus(basicFrame(1'b0), 0, 1'b0, -1);
    idleCycles(4, 1'b0);
    checkOutput("basic_nwrites", wr_log.size(), 3);
    for (int i = 0; i < wr_log.size() && i < 3; i++) begin
      checkOutput("basic_addr", wr_log[i].addr, i);
      checkOutput("basic_data", wr_log[i].data, basic_pl[i]);
      checkOutput("basic_contig_cycle", wr_log[i].cyc, wr_log[0].cyc + i);
    end
    checkOutput("basic_words_loaded", words_loaded, 3);
    checkOutput("basic_done", done, 1);
    checkOutput("basic_core_run", core_run, 1);
    checkOutput("model_sum_pin", m_sum, 32'h01108359);
    if (!CSUM_EN && wr_log.size() > 0)
      checkOutput("basic_run_latency", rise_cyc, wr_log[wr_log.size() - 1].cyc + 1);

    $display("[TB] restart from RUN");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("restart_core_run", core_run, 0);
    checkOutput("restart_s_ready", s_ready, 1);
    checkOutput("restart_words_loaded", words_loaded, 0);
    wr_log.delete();
    applyStimulus(makeFrame(6, 6, 1'b0), 20, 1'b0, -1);
    idleCycles(3, 1'b1);
    if (wr_log.size() > 0) checkOutput("reload_first_addr", wr_log[0].addr, 0);
    checkOutput("reload_done", done, 1);

`ifdef LOADER_CHECKSUM_EN
    $display("[TB] checksum mismatch");
    applyStimulus(basicFrame(1'b1), 0, 1'b0, -1);
    idleCycles(3, 1'b0);
    checkOutput("csum_bad_err", err, 1);
    checkOutput("csum_bad_core_run", core_run, 0);
`endif

    $display("[TB] bad lengths");
    applyStimulus(makeFrame(0, 2, 1'b0), 0, 1'b0, -1);
    idleCycles(2, 1'b1);
    checkOutput("len0_err", err, 1);
    wr_log.delete();
    applyStimulus(makeFrame(4097, 3, 1'b0), 0, 1'b0, -1);
    idleCycles(2, 1'b1);
    checkOutput("len4097_err", err, 1);
    checkOutput("len4097_no_write", wr_log.size(), 0);

    $display("[TB] full depth");
    wr_log.delete();
    applyStimulus(makeFrame(DEPTH, DEPTH, 1'b0), 0, 1'b0, -1);
    idleCycles(3, 1'b0);
    checkOutput("full_nwrites", wr_log.size(), DEPTH);
    last = wr_log.size() - 1;
    if (last >= 0) checkOutput("full_last_addr", wr_log[last].addr, 12'hFFF);
    checkOutput("full_words_loaded", words_loaded, 13'h1000);
    checkOutput("full_done", done, 1);

    $display("[TB] gapped random frames");
    for (int k = 0; k < 12; k++) begin
      int n = $urandom_range(1, 40);
      int h = ($urandom_range(9) == 0) ? 0 : n;
      wr_log.delete();
      applyStimulus(makeFrame(h, n, $urandom_range(3) == 0), 40, 1'b1, -1);
      idleCycles($urandom_range(1, 5), 1'b1);
      for (int i = 0; i < wr_log.size(); i++) checkOutput("gap_contig_addr", wr_log[i].addr, i);
    end

    $display("[TB] reset mid-load");
    applyStimulus(makeFrame(5, 5, 1'b0), 0, 1'b0, 3);
    checkOutput("midrst_core_run", core_run, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_mem_we", mem_we, 0);
    checkOutput("midrst_words_loaded", words_loaded, 0);
    checkOutput("midrst_mem_addr", mem_addr, 0);
    applyStimulus(makeFrame(5, 5, 1'b0), 25, 1'b1, -1);
    idleCycles(3, 1'b0);
    checkOutput("reload_after_rst_done", done, 1);
    checkOutput("reload_after_rst_words", words_loaded, 5);

    idleCycles(2, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
